interval_capture: RTL and testbench
===================================

Name: interval_capture

Overview:
Up-counting input-capture unit. It is the measuring counterpart to the team's down-count reload timer: that timer turns a loaded value into an elapsed time, and this block turns the elapsed time between two events into a value. It counts i_clk cycles between successive rising edges of a synchronous event input and presents each interval as a registered result with a valid/ack handshake. It sits beside the down-count timer in the timer subsystem and is used for period measurement and for checking that timer's expiry pulses.

Parameters:
DATA_WIDTH, 4, width of the interval counter and the captured result; legal for DATA_WIDTH >= 2.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  reset; asynchronous, active-low.
enable  input  1  measurement enable.
evt_in  input  1  event input, synchronous to i_clk; a rising edge marks an event.
cap_ack  input  1  consumer accepts the current result.
cap_out  output  DATA_WIDTH  captured interval in i_clk cycles, saturated.
cap_valid  output  1  cap_out holds an unconsumed result.
cap_ovf  output  1  captured interval exceeded 2^DATA_WIDTH-1.
overrun  output  1  sticky; an unacked result was overwritten.
busy  output  1  high while in RUN.

Behaviour:
- One clock; reset is asynchronous and active-low, ports i_clk and rst_n.
- Reset clears state (IDLE), cnt, evt_q, cap_out, cap_valid, cap_ovf and overrun to 0 immediately. Reset applied mid-RUN discards the interval in progress.
- Edge detect: evt_q is a register of evt_in. edge = evt_in & ~evt_q, combinational, so an edge is acted on at the same clock that samples it. A level held high is a single event.
- FSM states are IDLE and RUN. busy = (state == RUN).
- IDLE: if enable=1 and edge=1, go to RUN and set cnt <= 0. No capture occurs on this arming edge.
- RUN, enable=1, no edge: cnt <= cnt+1, saturating at all-ones (no wrap).
- RUN, enable=1, edge: capture, set cnt <= 0 and stay in RUN. Each capturing edge also starts the next interval, so measurement is back-to-back.
- Capture arithmetic: interval = cycles between the two sampled edges, t1-t0.
  - If cnt != all-ones: cap_out <= cnt+1 and cap_ovf <= 0.
  - If cnt == all-ones: cap_out <= all-ones and cap_ovf <= 1.
  - Therefore an interval of 2^W-1 gives no overflow, and an interval of 2^W or more gives overflow.
- Capture sets cap_valid <= 1. cap_out, cap_valid and cap_ovf change only at a capture or on reset, and are visible the cycle after the capturing clock edge.
- Handshake: cap_ack is sampled only while cap_valid=1, and is ignored when cap_valid=0. When sampled it clears cap_valid and overrun at the next edge. cap_out and cap_ovf hold their values.
- Capture while cap_valid=1 and cap_ack=0: the new result overwrites the old one, cap_valid stays 1 and overrun <= 1. overrun stays high until an ack.
- Capture in the same cycle as cap_ack=1: the capture wins, cap_valid stays 1 with the new data and overrun <= 0.
- enable=0 in any state: go to IDLE and clear cnt. The pending result, cap_valid and overrun are retained and can still be acked. Edges are ignored. After re-enable, the first edge only arms.
- evt_q tracks evt_in regardless of enable.

Test Plan:
1. Assert rst_n=0 with a clock running, then release -> all outputs 0 and busy=0. Assert rst_n=0 mid-RUN -> busy and cap_valid drop immediately, without waiting for a clock edge.
2. DATA_WIDTH=4, enable=1, evt_in pulses at cycles 10 and 15 -> busy from cycle 11. cap_out=5, cap_ovf=0, cap_valid=1 from cycle 16. Pulse cap_ack -> cap_valid=0 and cap_out stays 5.
3. Intervals of 15, 16 and 40, each acked -> results (15, ovf 0), (15, ovf 1), (15, ovf 1). cnt never wraps.
4. Edges at 0, 3 and 6 with no ack -> after the cycle-6 capture cap_out=3, cap_valid=1, overrun=1. Pulse cap_ack -> cap_valid=0 and overrun=0.
5. cap_ack high in the same cycle as a capturing edge (interval 7) -> cap_valid stays 1, cap_out=7, overrun=0.
6. Drop enable at the midpoint of an interval, then raise it again. Edges at 30 (arm) and 34 -> the pending result is kept while disabled, busy=0 while disabled, and the first capture after re-enable is cap_out=4.

Source files
------------

// File: rtl/interval_capture.sv
// Up-counting input-capture unit: measures i_clk cycles between successive rising edges
// of evt_in and presents each interval as a saturated result with a valid/ack handshake.
module interval_capture #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  evt_in,
  input  logic                  cap_ack,
  output logic [DATA_WIDTH-1:0] cap_out,
  output logic                  cap_valid,
  output logic                  cap_ovf,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] CntMax = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] CntOne = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    evt_q;
  logic [DATA_WIDTH-1:0]   cap_out_q, cap_out_d;
  logic                    cap_valid_q, cap_valid_d;
  logic                    cap_ovf_q, cap_ovf_d;
  logic                    overrun_q, overrun_d;
  logic                    evt_edge;
  logic                    capture;

  // Combinational edge so the event is acted on at the clock that samples it.
  assign evt_edge = evt_in & ~evt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (evt_edge) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        StRun: begin
          if (evt_edge) begin
            capture = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cap_out_d   = cap_out_q;
    cap_valid_d = cap_valid_q;
    cap_ovf_d   = cap_ovf_q;
    overrun_d   = overrun_q;
    if (capture) begin
      // A saturated counter means the interval reached 2^W or more.
      if (cnt_q == CntMax) begin
        cap_out_d = CntMax;
        cap_ovf_d = 1'b1;
      end else begin
        cap_out_d = cnt_q + CntOne;
        cap_ovf_d = 1'b0;
      end
      cap_valid_d = 1'b1;
      // Capture beats a simultaneous ack; only an unacked result counts as overrun.
      overrun_d   = cap_valid_q & ~cap_ack;
    end else if (cap_valid_q && cap_ack) begin
      cap_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      evt_q       <= 1'b0;
      cap_out_q   <= '0;
      cap_valid_q <= 1'b0;
      cap_ovf_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      evt_q       <= evt_in;
      cap_out_q   <= cap_out_d;
      cap_valid_q <= cap_valid_d;
      cap_ovf_q   <= cap_ovf_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cap_out   = cap_out_q;
  assign cap_valid = cap_valid_q;
  assign cap_ovf   = cap_ovf_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_interval_capture.sv
// Directed self-checking bench for interval_capture (DATA_WIDTH = 4).
module tb_interval_capture;

  localparam int unsigned DW = 4;

  logic          i_clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          evt_in;
  logic          cap_ack;
  logic [DW-1:0] cap_out;
  logic          cap_valid;
  logic          cap_ovf;
  logic          overrun;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  interval_capture #(
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk     (i_clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .evt_in    (evt_in),
    .cap_ack   (cap_ack),
    .cap_out   (cap_out),
    .cap_valid (cap_valid),
    .cap_ovf   (cap_ovf),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle event: the rising edge is sampled at the next clock.
  task automatic pulse();
    evt_in = 1'b1;
    tick();
    evt_in = 1'b0;
  endtask

  task automatic ack();
    cap_ack = 1'b1;
    tick();
    cap_ack = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    evt_in  = 1'b0;
    cap_ack = 1'b0;

    // 1. Reset
    idle(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(cap_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_out", 32'(cap_out), 0);
    chk("post_rst_valid", 32'(cap_valid), 0);
    chk("post_rst_ovf", 32'(cap_ovf), 0);
    chk("post_rst_overrun", 32'(overrun), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // 2. Interval 5
    enable = 1'b1;
    tick();
    pulse();
    chk("arm_busy", 32'(busy), 1);
    chk("arm_no_capture", 32'(cap_valid), 0);
    idle(4);
    chk("pre_cap_valid", 32'(cap_valid), 0);
    pulse();
    chk("i5_out", 32'(cap_out), 5);
    chk("i5_ovf", 32'(cap_ovf), 0);
    chk("i5_valid", 32'(cap_valid), 1);
    ack();
    chk("i5_ack_valid", 32'(cap_valid), 0);
    chk("i5_ack_out", 32'(cap_out), 5);

    // 3. Intervals 15, 16, 40 (interval counted from the previous capture edge)
    idle(13);
    pulse();
    chk("i15_out", 32'(cap_out), 15);
    chk("i15_ovf", 32'(cap_ovf), 0);
    chk("i15_valid", 32'(cap_valid), 1);
    ack();
    chk("i15_ack_valid", 32'(cap_valid), 0);
    idle(14);
    pulse();
    chk("i16_out", 32'(cap_out), 15);
    chk("i16_ovf", 32'(cap_ovf), 1);
    ack();
    idle(38);
    pulse();
    chk("i40_out", 32'(cap_out), 15);
    chk("i40_ovf", 32'(cap_ovf), 1);
    chk("i40_valid", 32'(cap_valid), 1);
    ack();
    chk("i40_ack_valid", 32'(cap_valid), 0);
    chk("i40_ack_ovf_held", 32'(cap_ovf), 1);

    // 4. Edges at 0 (arm), 3, 6 with no ack
    enable = 1'b0;
    tick();
    enable = 1'b1;
    pulse();
    idle(2);
    pulse();
    chk("ovr_first_out", 32'(cap_out), 3);
    chk("ovr_first_overrun", 32'(overrun), 0);
    idle(2);
    pulse();
    chk("ovr_out", 32'(cap_out), 3);
    chk("ovr_valid", 32'(cap_valid), 1);
    chk("ovr_overrun", 32'(overrun), 1);
    ack();
    chk("ovr_ack_valid", 32'(cap_valid), 0);
    chk("ovr_ack_overrun", 32'(overrun), 0);

    // 5. Ack coincident with a capture while a result is pending
    idle(1);
    pulse();
    chk("pend_valid", 32'(cap_valid), 1);
    idle(6);
    cap_ack = 1'b1;
    evt_in  = 1'b1;
    tick();
    cap_ack = 1'b0;
    evt_in  = 1'b0;
    chk("coinc_valid", 32'(cap_valid), 1);
    chk("coinc_out", 32'(cap_out), 7);
    chk("coinc_overrun", 32'(overrun), 0);

    // 6. Disable mid-interval, re-enable, arm then capture interval 4
    idle(3);
    enable = 1'b0;
    tick();
    chk("dis_busy", 32'(busy), 0);
    chk("dis_valid_kept", 32'(cap_valid), 1);
    pulse();
    chk("dis_edge_ignored_busy", 32'(busy), 0);
    chk("dis_edge_ignored_out", 32'(cap_out), 7);
    idle(2);
    enable = 1'b1;
    tick();
    chk("reen_busy", 32'(busy), 0);
    pulse();
    chk("reen_arm_busy", 32'(busy), 1);
    chk("reen_arm_out", 32'(cap_out), 7);
    idle(3);
    pulse();
    chk("reen_out", 32'(cap_out), 4);
    chk("reen_overrun", 32'(overrun), 1);

    // 1b. Asynchronous reset mid-RUN, checked before any further clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_valid", 32'(cap_valid), 0);
    chk("async_rst_out", 32'(cap_out), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
